// File: rtl/joy_serial_scan.sv
// Serial joystick chain scanner for 74HC165-style PISO registers, NJOY pads of NBITS each.
// Optional two-frame consistency filter enabled by defining JOY_DEBOUNCE_EN.
module joy_serial_scan #(
  parameter int unsigned NJOY       = 2,
  parameter int unsigned NBITS      = 8,
  parameter int unsigned DIV        = 50,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned GAP        = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  joyCk,
  output logic                  joyLd,
  output logic                  joyS,
  input  logic                  joyD,
  output logic [NJOY*NBITS-1:0] joy,
  output logic                  joyStb,
  output logic                  busy
);

  localparam int unsigned Total = NJOY * NBITS;
  localparam int unsigned CntW  = (Total > 1) ? $clog2(Total) : 1;
  localparam int unsigned DivW  = $clog2(DIV);

  localparam logic [CntW-1:0] LastBit = CntW'(Total - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [7:0]      GapLast = 8'(GAP);
  localparam logic            InvBit  = (ACTIVE_LOW != 0);

  typedef enum logic [2:0] {StIdle, StLoad, StSample, StClkHi, StDone} state_t;

  state_t            stateQ, stateD;
  logic [DivW-1:0]   divCntQ;
  logic              ce;
  logic [CntW-1:0]   bitCntQ, bitCntD;
  logic [7:0]        gapCntQ, gapCntD;
  logic [Total-1:0]  shiftQ, shiftD;
  logic [Total-1:0]  joyOutQ, joyOutD;
  logic              joyCkQ, joyCkD;
  logic              joyLdQ, joyLdD;
  logic              busyQ, busyD;
  logic              joyStbQ, joyStbD;
`ifdef JOY_DEBOUNCE_EN
  logic [Total-1:0]  prevQ, prevD;
`endif

  assign ce = (divCntQ == DivLast);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divCntQ <= '0;
    end else begin
      divCntQ <= ce ? '0 : divCntQ + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    if (ce) begin
      unique case (stateQ)
        StIdle:   if (enable) stateD = StLoad;
        StLoad:   stateD = StSample;
        StSample: stateD = (bitCntQ == LastBit) ? StDone : StClkHi;
        StClkHi:  stateD = StSample;
        StDone:   if (gapCntQ == GapLast) stateD = StIdle;
        default:  stateD = StIdle;
      endcase
    end
  end

  // Datapath and registered outputs; every change is gated by ce except the strobe clear.
  always_comb begin
    bitCntD = bitCntQ;
    gapCntD = gapCntQ;
    shiftD  = shiftQ;
    joyOutD = joyOutQ;
    joyCkD  = joyCkQ;
    joyLdD  = joyLdQ;
    busyD   = busyQ;
    joyStbD = 1'b0;
`ifdef JOY_DEBOUNCE_EN
    prevD   = prevQ;
`endif
    if (ce) begin
      unique case (stateQ)
        StIdle: begin
          if (enable) begin
            joyLdD  = 1'b0;
            joyCkD  = 1'b0;
            bitCntD = '0;
            busyD   = 1'b1;
          end else begin
            busyD = 1'b0;
          end
        end
        StLoad: begin
          joyLdD  = 1'b1;
          gapCntD = '0;
        end
        StSample: begin
          shiftD[bitCntQ] = joyD ^ InvBit;
          bitCntD = bitCntQ + 1'b1;
          // No trailing shift clock after the last bit.
          if (bitCntQ != LastBit) joyCkD = 1'b1;
        end
        StClkHi: begin
          joyCkD = 1'b0;
        end
        StDone: begin
          if (gapCntQ == 8'd0) begin
`ifdef JOY_DEBOUNCE_EN
            if ((shiftQ == prevQ) && (shiftQ != joyOutQ)) begin
              joyOutD = shiftQ;
              joyStbD = 1'b1;
            end
            prevD = shiftQ;
`else
            joyOutD = shiftQ;
            joyStbD = 1'b1;
`endif
          end
          if (gapCntQ == GapLast) begin
            busyD = 1'b0;
          end else begin
            gapCntD = gapCntQ + 8'd1;
          end
        end
        default: begin
          busyD = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitCntQ <= '0;
      gapCntQ <= '0;
      shiftQ  <= '0;
      joyOutQ <= '0;
      joyCkQ  <= 1'b0;
      joyLdQ  <= 1'b1;
      busyQ   <= 1'b0;
      joyStbQ <= 1'b0;
    end else begin
      bitCntQ <= bitCntD;
      gapCntQ <= gapCntD;
      shiftQ  <= shiftD;
      joyOutQ <= joyOutD;
      joyCkQ  <= joyCkD;
      joyLdQ  <= joyLdD;
      busyQ   <= busyD;
      joyStbQ <= joyStbD;
    end
  end

`ifdef JOY_DEBOUNCE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prevQ <= '0;
    end else begin
      prevQ <= prevD;
    end
  end
`endif

  assign joyCk  = joyCkQ;
  assign joyLd  = joyLdQ;
  assign joyS   = 1'b1;
  assign joy    = joyOutQ;
  assign joyStb = joyStbQ;
  assign busy   = busyQ;

endmodule
